// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types for the 5-stage core control path. Holds the
//               memory-wait FSM encoding, the hazard priority encoding and
//               the default memory timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } fsm_state_t;

  // Ordered so that a larger code means a higher-priority action.
  typedef enum logic [2:0] {
    HZ_NORMAL    = 3'd0,
    HZ_JUMP      = 3'd1,
    HZ_LOAD_USE  = 3'd2,
    HZ_BRANCH    = 3'd3,
    HZ_MEM_STALL = 3'd4,
    HZ_ERROR     = 3'd5
  } hazard_t;

  // Actions that cost a stall cycle. A freeze caused by the terminal error
  // state is deliberately excluded.
  function automatic logic is_stall_action(input hazard_t h);
    return (h == HZ_MEM_STALL) || (h == HZ_LOAD_USE);
  endfunction

  // Actions that redirect the fetch stream.
  function automatic logic is_redirect_action(input hazard_t h);
    return (h == HZ_BRANCH) || (h == HZ_JUMP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Purely combinational hazard decode. Produces the memory
//               stall and load-use conditions and picks the winning action
//               by fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       error_state,
  input  logic       mem_access,
  input  logic       mem_ready,
  input  logic       branch_taken,
  input  logic       id_jump,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  output logic       mstall,
  output hazard_t    hazard
);

  logic lu;

  // Raw hazard conditions; $zero as a load target never creates a dependency.
  always_comb begin
    mstall = mem_access && !mem_ready;
    lu     = idex_mem_read && (idex_rt != 5'd0) &&
             ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

  // Fixed-priority selection: error > memory stall > branch > load-use > jump.
  always_comb begin
    hazard = HZ_NORMAL;
    if (error_state) begin
      hazard = HZ_ERROR;
    end else if (mstall) begin
      hazard = HZ_MEM_STALL;
    end else if (branch_taken) begin
      hazard = HZ_BRANCH;
    end else if (lu) begin
      hazard = HZ_LOAD_USE;
    end else if (id_jump) begin
      hazard = HZ_JUMP;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline control unit. Drives the write-enable and flush
//               controls of the four pipeline registers and the PC, tracks
//               data-memory wait cycles with a timeout, and keeps stall and
//               redirect performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        IFID_RsAddr,
  input  logic [4:0]        IFID_RtAddr,
  input  logic              ID_Jump,
  input  logic              IDEX_MemRead,
  input  logic [4:0]        IDEX_RtAddr,
  input  logic              EX_BranchTaken,
  input  logic              EXMEM_MemAccess,
  input  logic              Mem_Ready,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IDEX_Write,
  output logic              EXMEM_Write,
  output logic              MEMWB_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Flush,
  output logic              EXMEM_Flush,
  output logic              MEMWB_Flush,
  output logic              Mem_Error,
  output logic [PERF_W-1:0] Stall_Count,
  output logic [PERF_W-1:0] Flush_Count
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  fsm_state_t        state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mstall;
  hazard_t           hazard;

  hazard_detect u_detect (
    .error_state   (state == ST_ERROR),
    .mem_access    (EXMEM_MemAccess),
    .mem_ready     (Mem_Ready),
    .branch_taken  (EX_BranchTaken),
    .id_jump       (ID_Jump),
    .idex_mem_read (IDEX_MemRead),
    .idex_rt       (IDEX_RtAddr),
    .ifid_rs       (IFID_RsAddr),
    .ifid_rt       (IFID_RtAddr),
    .mstall        (mstall),
    .hazard        (hazard)
  );

  // Memory-wait FSM state and wait-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: count not-ready cycles and trap once the budget is spent.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (mstall) begin
          state_nxt    = ST_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (Mem_Ready || !EXMEM_MemAccess) begin
          // Either completed or the access was withdrawn.
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_ERROR: begin
        // Terminal until reset.
      end
      default: begin
        state_nxt    = ST_IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Pipeline controls; reset holds every stage and bubbles all of them.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    EXMEM_Write = 1'b1;
    MEMWB_Write = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    MEMWB_Flush = 1'b0;
    if (!reset) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Flush  = 1'b1;
      EXMEM_Flush = 1'b1;
      MEMWB_Flush = 1'b1;
    end else begin
      case (hazard)
        HZ_ERROR, HZ_MEM_STALL: begin
          // Freeze IF..MEM; WB gets a bubble so the stalled access retires once.
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Write  = 1'b0;
          EXMEM_Write = 1'b0;
          MEMWB_Write = 1'b0;
          MEMWB_Flush = 1'b1;
        end
        HZ_BRANCH: begin
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end
        HZ_LOAD_USE: begin
          PC_Write   = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
        end
        HZ_JUMP: begin
          IFID_Flush = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky timeout flag, set on the edge that enters the error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Mem_Error <= 1'b0;
    end else if (state_nxt == ST_ERROR) begin
      Mem_Error <= 1'b1;
    end
  end

  // Performance counters, wrapping naturally at their width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (is_stall_action(hazard)) begin
        Stall_Count <= Stall_Count + PERF_W'(1);
      end
      if (is_redirect_action(hazard)) begin
        Flush_Count <= Flush_Count + PERF_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl with a small memory
//               timeout so the error path is reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int TO = 4;

  // {PC, IFID_W, IDEX_W, EXMEM_W, MEMWB_W, IFID_F, IDEX_F, EXMEM_F, MEMWB_F}
  localparam logic [8:0] C_NORM  = 9'b1_1111_0000;
  localparam logic [8:0] C_STALL = 9'b0_0000_0001;
  localparam logic [8:0] C_BR    = 9'b1_1111_1100;
  localparam logic [8:0] C_LU    = 9'b0_0111_0100;
  localparam logic [8:0] C_JMP   = 9'b1_1111_1000;
  localparam logic [8:0] C_RST   = 9'b0_0000_1111;

  localparam int K_NORM  = 0;
  localparam int K_STALL = 1;
  localparam int K_BR    = 2;
  localparam int K_LU    = 3;
  localparam int K_JMP   = 4;
  localparam int K_ERR   = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IFID_RsAddr, IFID_RtAddr, IDEX_RtAddr;
  logic        ID_Jump, IDEX_MemRead, EX_BranchTaken, EXMEM_MemAccess, Mem_Ready;
  logic        PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
  logic        IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush;
  logic        Mem_Error;
  logic [31:0] Stall_Count, Flush_Count;
  logic [8:0]  ctl_bus;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .PERF_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .IFID_RsAddr     (IFID_RsAddr),
    .IFID_RtAddr     (IFID_RtAddr),
    .ID_Jump         (ID_Jump),
    .IDEX_MemRead    (IDEX_MemRead),
    .IDEX_RtAddr     (IDEX_RtAddr),
    .EX_BranchTaken  (EX_BranchTaken),
    .EXMEM_MemAccess (EXMEM_MemAccess),
    .Mem_Ready       (Mem_Ready),
    .PC_Write        (PC_Write),
    .IFID_Write      (IFID_Write),
    .IDEX_Write      (IDEX_Write),
    .EXMEM_Write     (EXMEM_Write),
    .MEMWB_Write     (MEMWB_Write),
    .IFID_Flush      (IFID_Flush),
    .IDEX_Flush      (IDEX_Flush),
    .EXMEM_Flush     (EXMEM_Flush),
    .MEMWB_Flush     (MEMWB_Flush),
    .Mem_Error       (Mem_Error),
    .Stall_Count     (Stall_Count),
    .Flush_Count     (Flush_Count)
  );

  assign ctl_bus = {PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
                    IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush};

  typedef struct {
    string       name;
    logic [4:0]  rs, rt, ex_rt;
    logic        memrd, br, jmp, acc, rdy;
    logic [8:0]  ctl;
    logic        err;
    logic [31:0] sc, fc;
  } vec_t;

  vec_t        stim[$];
  vec_t        sb[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_sc = '0;
  logic [31:0] exp_fc = '0;

  // Queue one cycle of stimulus with the outcome the cycle must produce.
  task automatic add(input string name, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] ex_rt, input logic memrd, input logic br,
                     input logic jmp, input logic acc, input logic rdy,
                     input int kind, input logic err);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.ex_rt = ex_rt;
    v.memrd = memrd; v.br = br; v.jmp = jmp; v.acc = acc; v.rdy = rdy;
    v.err = err;
    case (kind)
      K_STALL: begin v.ctl = C_STALL; exp_sc = exp_sc + 1; end
      K_LU:    begin v.ctl = C_LU;    exp_sc = exp_sc + 1; end
      K_BR:    begin v.ctl = C_BR;    exp_fc = exp_fc + 1; end
      K_JMP:   begin v.ctl = C_JMP;   exp_fc = exp_fc + 1; end
      K_ERR:   v.ctl = C_STALL;
      default: v.ctl = C_NORM;
    endcase
    v.sc = exp_sc;
    v.fc = exp_fc;
    stim.push_back(v);
  endtask

  // Drive one cycle's inputs and register its expectation on the scoreboard.
  task automatic apply(input vec_t v);
    IFID_RsAddr = v.rs; IFID_RtAddr = v.rt; IDEX_RtAddr = v.ex_rt;
    IDEX_MemRead = v.memrd; EX_BranchTaken = v.br; ID_Jump = v.jmp;
    EXMEM_MemAccess = v.acc; Mem_Ready = v.rdy;
    sb.push_back(v);
  endtask

  task automatic clear_inputs();
    IFID_RsAddr = '0; IFID_RtAddr = '0; IDEX_RtAddr = '0;
    IDEX_MemRead = 1'b0; EX_BranchTaken = 1'b0; ID_Jump = 1'b0;
    EXMEM_MemAccess = 1'b0; Mem_Ready = 1'b0;
  endtask

  task automatic test_reset();
    vec_t e;
    reset = 1'b0;
    clear_inputs();
    EXMEM_MemAccess = 1'b1;   // a pending stall must not count during reset
    @(posedge clk); #2;
    n_vec++;
    if (ctl_bus !== C_RST) begin
      n_miss++;
      $display("FAIL reset_ctl: got %b expected %b", ctl_bus, C_RST);
    end
    n_vec++;
    if (Mem_Error !== 1'b0 || Stall_Count !== 32'd0 || Flush_Count !== 32'd0) begin
      n_miss++;
      $display("FAIL reset_regs: got err=%b stall=%0d flush=%0d expected 0/0/0",
               Mem_Error, Stall_Count, Flush_Count);
    end
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    add("after_reset", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM, 0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_load_use();
    vec_t e;
    add("lu_rs",      5'd8, 5'd0, 5'd8, 1, 0, 0, 0, 0, K_LU,   0);
    add("lu_release", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM, 0);
    add("lu_rt",      5'd3, 5'd9, 5'd9, 1, 0, 0, 0, 0, K_LU,   0);
    add("lu_zero",    5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, K_NORM, 0);
    add("lu_nomatch", 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 0, K_NORM, 0);
    add("lu_noload",  5'd8, 5'd8, 5'd8, 0, 0, 0, 0, 0, K_NORM, 0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_branch_lu();
    vec_t e;
    add("br_with_lu", 5'd8, 5'd0, 5'd8, 1, 1, 0, 0, 0, K_BR,   0);
    add("br_after",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM, 0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_jump();
    vec_t e;
    add("jump",       5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, K_JMP,  0);
    add("jump_after", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM, 0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_mem_wait();
    vec_t e;
    // N = TO-1 not-ready cycles: exactly N stalls and no error.
    add("mw_stall1", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("mw_stall2", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("mw_stall3", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("mw_ready",  5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, K_NORM,  0);
    add("mw_idle",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM,  0);
    // Immediate ready costs nothing.
    add("mw_fast",   5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, K_NORM,  0);
    // Withdrawn access restarts the wait budget.
    add("mw_drop_a", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("mw_drop_b", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM,  0);
    add("mw_re1",    5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("mw_re2",    5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("mw_re3",    5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("mw_re_rdy", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, K_NORM,  0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_mem_branch();
    vec_t e;
    add("mb_stall1", 5'd8, 5'd0, 5'd8, 1, 1, 0, 1, 0, K_STALL, 0);
    add("mb_stall2", 5'd8, 5'd0, 5'd8, 1, 1, 0, 1, 0, K_STALL, 0);
    add("mb_ready",  5'd8, 5'd0, 5'd8, 1, 1, 0, 1, 1, K_BR,    0);
    add("mb_after",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM,  0);
    // Load-use held across a memory stall is applied once memory completes.
    add("ml_stall",  5'd7, 5'd0, 5'd7, 1, 0, 0, 1, 0, K_STALL, 0);
    add("ml_ready",  5'd7, 5'd0, 5'd7, 1, 0, 0, 1, 1, K_LU,    0);
    add("ml_after",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM,  0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t e;
    add("bb_lu_jmp", 5'd4, 5'd0, 5'd4, 1, 0, 1, 0, 0, K_LU,    0);
    add("bb_jmp",    5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, K_JMP,   0);
    add("bb_br_jmp", 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, K_BR,    0);
    add("bb_st_jmp", 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, K_STALL, 0);
    add("bb_rd_jmp", 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, K_JMP,   0);
    add("bb_idle",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM,  0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t e;
    // Error rises on the edge ending the TO-th stalled cycle.
    add("to_stall1", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("to_stall2", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("to_stall3", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("to_stall4", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 1);
    // Terminal: stays frozen and uncounted whatever the inputs do.
    add("to_err1",   5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 1, K_ERR,   1);
    add("to_err2",   5'd5, 5'd0, 5'd5, 1, 0, 0, 1, 1, K_ERR,   1);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
    // Asynchronous reset in the middle of the error state.
    clear_inputs();
    reset = 1'b0;
    #2;
    exp_sc = '0;
    exp_fc = '0;
    n_vec++;
    if (Mem_Error !== 1'b0 || Stall_Count !== 32'd0 || Flush_Count !== 32'd0 || ctl_bus !== C_RST) begin
      n_miss++;
      $display("FAIL to_async_reset: got err=%b stall=%0d flush=%0d ctl=%b expected 0/0/0 ctl=%b",
               Mem_Error, Stall_Count, Flush_Count, ctl_bus, C_RST);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    add("to_resume",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, K_NORM,  0);
    add("to_jump",    5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, K_JMP,   0);
    add("to_stall_n", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, K_STALL, 0);
    add("to_ready_n", 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, K_NORM,  0);
    while (stim.size() > 0) begin
      apply(stim.pop_front());
      @(negedge clk); e = sb.pop_front(); n_vec++;
      if (ctl_bus !== e.ctl) begin n_miss++; $display("FAIL %s ctl: got %b expected %b", e.name, ctl_bus, e.ctl); end
      @(posedge clk); #1; n_vec++;
      if (Mem_Error !== e.err || Stall_Count !== e.sc || Flush_Count !== e.fc) begin
        n_miss++;
        $display("FAIL %s regs: got err=%b stall=%0d flush=%0d expected err=%b stall=%0d flush=%0d",
                 e.name, Mem_Error, Stall_Count, Flush_Count, e.err, e.sc, e.fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_lu();
    test_jump();
    test_mem_wait();
    test_mem_branch();
    test_back_to_back();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
